// File: rtl/unidad_control_multiciclo_if.sv
// Instruction handshake, memory handshake and datapath control bundle of the multicycle control unit.
// master = instruction/memory side, slave = control unit.
interface unidad_control_multiciclo_if #(
    parameter int COUNT_W = 16
);
    logic               inst_valid;
    logic               inst_ready;
    logic [5:0]         opcode;
    logic               mem_ready;
    logic [2:0]         codigo_UC;
    logic               reg_dst;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               instr_done;
    logic               illegal_op;
    logic               mem_error;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        output inst_valid, opcode, mem_ready,
        input  inst_ready, codigo_UC, reg_dst, alu_src, mem_read, mem_write,
               mem_to_reg, reg_write, instr_done, illegal_op, mem_error, instr_count
    );

    modport slave (
        input  inst_valid, opcode, mem_ready,
        output inst_ready, codigo_UC, reg_dst, alu_src, mem_read, mem_write,
               mem_to_reg, reg_write, instr_done, illegal_op, mem_error, instr_count
    );
endinterface

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS-subset main control: IDLE/DECODE/EXEC/MEM/WB FSM with memory-wait timeout.
// Latency 4 (R/addi), 5+w (lw), 4+w (sw), 2 (illegal); accepts only in IDLE, stalls in MEM on mem_ready.
module unidad_control_multiciclo #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    unidad_control_multiciclo_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t             state;
    logic [5:0]         opcode_q;
    logic [7:0]         wait_cnt;
    logic [COUNT_W-1:0] count_q;

    logic is_r, is_lw, is_sw, is_addi, is_illegal, timeout_hit;
    logic [2:0] codigo;
    logic reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic done, illegal, mem_err;

    assign is_r        = (opcode_q == OP_R);
    assign is_lw       = (opcode_q == OP_LW);
    assign is_sw       = (opcode_q == OP_SW);
    assign is_addi     = (opcode_q == OP_ADDI);
    assign is_illegal  = !(is_r || is_lw || is_sw || is_addi);
    assign timeout_hit = (wait_cnt == LAST_WAIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            opcode_q <= '0;
            wait_cnt <= '0;
            count_q  <= '0;
        end else begin
            if (done)
                count_q <= count_q + 1'b1;
            case (state)
                IDLE: begin
                    if (bus.inst_valid) begin
                        opcode_q <= bus.opcode;
                        state    <= DECODE;
                    end
                end
                DECODE: state <= is_illegal ? IDLE : EXEC;
                EXEC: begin
                    if (is_lw || is_sw) begin
                        wait_cnt <= '0;
                        state    <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (bus.mem_ready)
                        state <= is_lw ? WB : IDLE;
                    else if (timeout_hit)
                        state <= IDLE;
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The MEM-exit pulses (sw retire, timeout abort) must land in the same cycle
    // the memory answers (or fails to), so they are the only terms gated by mem_ready.
    always_comb begin
        codigo     = 3'b111;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        case (state)
            DECODE: illegal = is_illegal;
            EXEC: begin
                codigo  = is_r ? 3'b000 : 3'b001;
                alu_src = !is_r;
            end
            MEM: begin
                alu_src   = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
                done      = is_sw && bus.mem_ready;
                mem_err   = !bus.mem_ready && timeout_hit;
            end
            WB: begin
                alu_src    = !is_r;
                reg_write  = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.inst_ready  = (state == IDLE) && rst_n;
    assign bus.codigo_UC   = codigo;
    assign bus.reg_dst     = reg_dst;
    assign bus.alu_src     = alu_src;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.reg_write   = reg_write;
    assign bus.instr_done  = done;
    assign bus.illegal_op  = illegal;
    assign bus.mem_error   = mem_err;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed-vector bench for unidad_control_multiciclo (MEM_TIMEOUT=16, COUNT_W=4).
module tb_unidad_control_multiciclo;
    localparam logic [5:0] R_OP = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BEQ  = 6'b000100;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    unidad_control_multiciclo_if #(.COUNT_W(4)) bus ();

    unidad_control_multiciclo #(.MEM_TIMEOUT(16), .COUNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {codigo_UC, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, instr_done, illegal_op, mem_error}
    function automatic logic [11:0] mk(input logic [2:0] cod, input logic [8:0] bits);
        return {cod, bits};
    endfunction

    localparam logic [11:0] IDLE_CTL = 12'b111_000000000;

    function automatic logic [11:0] ctl();
        return {bus.codigo_UC, bus.reg_dst, bus.alu_src, bus.mem_read, bus.mem_write,
                bus.mem_to_reg, bus.reg_write, bus.instr_done, bus.illegal_op, bus.mem_error};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, apply this cycle's inputs, let combinational outputs settle.
    task automatic cyc(input logic v, input logic [5:0] op, input logic mr);
        @(posedge clk);
        #1;
        bus.inst_valid = v;
        bus.opcode     = op;
        bus.mem_ready  = mr;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.inst_valid = 1'b0;
        bus.opcode     = '0;
        bus.mem_ready  = 1'b0;

        // Reset
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, R_OP, 1'b0);
            check("rst_ready_low", 16'(bus.inst_ready), 16'h0);
        end
        rst_n = 1'b1;
        bus.inst_valid = 1'b0;
        #1;
        check("rst_ctl",   16'(ctl()), 16'(IDLE_CTL));
        check("rst_count", 16'(bus.instr_count), 16'h0);
        check("rst_ready", 16'(bus.inst_ready), 16'h1);

        // R-type: c0..c4
        cyc(1'b1, R_OP, 1'b0);
        check("r_c0_ready", 16'(bus.inst_ready), 16'h1);
        cyc(1'b0, R_OP, 1'b0);
        check("r_c1_ctl", 16'(ctl()), 16'(IDLE_CTL));
        check("r_c1_ready", 16'(bus.inst_ready), 16'h0);
        cyc(1'b0, R_OP, 1'b0);
        check("r_c2_ctl", 16'(ctl()), 16'(mk(3'b000, 9'b000000000)));
        cyc(1'b0, R_OP, 1'b0);
        check("r_c3_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b100001100)));
        cyc(1'b0, R_OP, 1'b0);
        check("r_c4_ready", 16'(bus.inst_ready), 16'h1);
        check("r_count", 16'(bus.instr_count), 16'h1);

        // lw with two wait cycles: MEM c3..c5, WB c6, next accept c7
        cyc(1'b1, LW, 1'b0);
        cyc(1'b0, LW, 1'b0);
        check("lw_c1_ctl", 16'(ctl()), 16'(IDLE_CTL));
        cyc(1'b0, LW, 1'b0);
        check("lw_exec_ctl", 16'(ctl()), 16'(mk(3'b001, 9'b010000000)));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, LW, (i == 2));
            check("lw_mem_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b011000000)));
        end
        cyc(1'b0, LW, 1'b0);
        check("lw_wb_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b010011100)));
        cyc(1'b0, LW, 1'b0);
        check("lw_c7_ready", 16'(bus.inst_ready), 16'h1);
        check("lw_count", 16'(bus.instr_count), 16'h2);

        // sw with memory ready at once
        cyc(1'b1, SW, 1'b0);
        cyc(1'b0, SW, 1'b0);
        check("sw_c1_ctl", 16'(ctl()), 16'(IDLE_CTL));
        cyc(1'b0, SW, 1'b0);
        check("sw_exec_ctl", 16'(ctl()), 16'(mk(3'b001, 9'b010000000)));
        cyc(1'b0, SW, 1'b1);
        check("sw_mem_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b010100100)));
        cyc(1'b0, SW, 1'b0);
        check("sw_c4_ready", 16'(bus.inst_ready), 16'h1);
        check("sw_count", 16'(bus.instr_count), 16'h3);

        // addi
        cyc(1'b1, ADDI, 1'b0);
        cyc(1'b0, ADDI, 1'b0);
        cyc(1'b0, ADDI, 1'b0);
        check("addi_exec_ctl", 16'(ctl()), 16'(mk(3'b001, 9'b010000000)));
        cyc(1'b0, ADDI, 1'b0);
        check("addi_wb_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b010001100)));
        cyc(1'b0, ADDI, 1'b0);
        check("addi_count", 16'(bus.instr_count), 16'h4);

        // Illegal opcode
        cyc(1'b1, BEQ, 1'b0);
        cyc(1'b0, BEQ, 1'b0);
        check("ill_c1_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b000000010)));
        cyc(1'b0, BEQ, 1'b0);
        check("ill_c2_ready", 16'(bus.inst_ready), 16'h1);
        check("ill_count", 16'(bus.instr_count), 16'h4);

        // lw timeout: memory never answers, abort in MEM cycle 16
        cyc(1'b1, LW, 1'b0);
        cyc(1'b0, LW, 1'b0);
        cyc(1'b0, LW, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, LW, 1'b0);
            if (i < 16)
                check("to_mem_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b011000000)));
            else
                check("to_abort_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b011000001)));
        end
        cyc(1'b0, LW, 1'b0);
        check("to_idle_ready", 16'(bus.inst_ready), 16'h1);
        check("to_idle_ctl", 16'(ctl()), 16'(IDLE_CTL));
        check("to_count", 16'(bus.instr_count), 16'h4);

        // lw: memory answers in MEM cycle 16, completes normally
        cyc(1'b1, LW, 1'b0);
        cyc(1'b0, LW, 1'b0);
        cyc(1'b0, LW, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, LW, (i == 16));
            check("late_mem_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b011000000)));
        end
        cyc(1'b0, LW, 1'b0);
        check("late_wb_ctl", 16'(ctl()), 16'(mk(3'b111, 9'b010011100)));
        cyc(1'b0, LW, 1'b0);
        check("late_ready", 16'(bus.inst_ready), 16'h1);
        check("late_count", 16'(bus.instr_count), 16'h5);

        // Reset during MEM
        cyc(1'b1, LW, 1'b0);
        cyc(1'b0, LW, 1'b0);
        cyc(1'b0, LW, 1'b0);
        cyc(1'b0, LW, 1'b0);
        check("mrst_mem_read", 16'(bus.mem_read), 16'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mrst_ctl", 16'(ctl()), 16'(IDLE_CTL));
        check("mrst_ready", 16'(bus.inst_ready), 16'h1);
        check("mrst_count", 16'(bus.instr_count), 16'h0);

        // Back-to-back R-type with inst_valid held high; 4-bit counter wraps
        cyc(1'b1, R_OP, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            repeat (4) cyc(1'b1, R_OP, 1'b0);
            check("wrap_count", 16'(bus.instr_count), 16'(i % 16));
        end
        repeat (5) cyc(1'b0, R_OP, 1'b0);
        check("wrap_final_ready", 16'(bus.inst_ready), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
